// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier that borrows the core's external 32-bit adder, one add per cycle.
// Optional signed mode (sgn port plus two negate-fixup states) is enabled by defining MULT_SIGNED_EN.
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULT_SIGNED_EN
  input  logic             sgn,
`endif
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX1, S_FIX2} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CNT_W-1:0] count_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] a_ld_d;
  logic [WIDTH-1:0] b_ld_d;
  logic [WIDTH-1:0] add_x_d;
  logic [WIDTH-1:0] add_y_d;
  logic             add_cin_d;
  logic             last_step_d;

`ifdef MULT_SIGNED_EN
  logic sgn_q;
  logic neg_q;
  logic carry_q;

  // Signed operands are multiplied as magnitudes; the sign is restored in FIX1/FIX2.
  assign a_ld_d = (sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_ld_d = (sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
`else
  assign a_ld_d = a;
  assign b_ld_d = b;
`endif

  assign last_step_d = (count_q == CNT_W'(WIDTH - 1));

  // Adder operands are combinational so the sum returns within the same cycle.
  always_comb begin
    add_x_d   = '0;
    add_y_d   = '0;
    add_cin_d = 1'b0;
    case (state_q)
      S_RUN: begin
        add_x_d = hi_q;
        add_y_d = lo_q[0] ? mcand_q : '0;
      end
`ifdef MULT_SIGNED_EN
      S_FIX1: begin
        add_x_d   = neg_q ? ~lo_q : lo_q;
        add_cin_d = neg_q;
      end
      S_FIX2: begin
        add_x_d   = neg_q ? ~hi_q : hi_q;
        add_cin_d = neg_q & carry_q;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULT_SIGNED_EN
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mcand_q <= a_ld_d;
            hi_q    <= '0;
            lo_q    <= b_ld_d;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
`ifdef MULT_SIGNED_EN
            sgn_q   <= sgn;
            neg_q   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
          end
        end
        S_RUN: begin
          // Carry-out becomes the new MSB while the product shifts right one bit.
          {hi_q, lo_q} <= {add_cout, add_sum, lo_q[WIDTH-1:1]};
          count_q      <= count_q + CNT_W'(1);
          if (last_step_d) begin
`ifdef MULT_SIGNED_EN
            if (sgn_q) begin
              state_q <= S_FIX1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
`else
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`endif
          end
        end
`ifdef MULT_SIGNED_EN
        S_FIX1: begin
          lo_q    <= add_sum;
          carry_q <= add_cout;
          state_q <= S_FIX2;
        end
        S_FIX2: begin
          hi_q    <= add_sum;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign add_x   = add_x_d;
  assign add_y   = add_y_d;
  assign add_cin = add_cin_d;
  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural model of the shared 32-bit adder.
// Signed-mode cases are included when MULT_SIGNED_EN is defined.
module tb_mult_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] add_x;
  logic [31:0] add_y;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MULT_SIGNED_EN
  logic        sgn;
`endif

  int errors = 0;
  int checks = 0;

  mult_seq_ctrl #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
`ifdef MULT_SIGNED_EN
    .sgn      (sgn),
`endif
    .add_x    (add_x),
    .add_y    (add_y),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  // FULL_ADDER_32 stand-in
  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    a     = x;
    b     = y;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, output int lat);
    lat = base;
    while (!done && lat < 80) begin
      cyc();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a     = 32'h1234;
    b     = 32'h5678;
    repeat (2) cyc();
    start = 1'b0;
    checks++; if (hi !== 32'd0)      begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0)      begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (add_x !== 32'd0)   begin errors++; $display("FAIL reset_add_x got=%h exp=0", add_x); end
    checks++; if (add_y !== 32'd0)   begin errors++; $display("FAIL reset_add_y got=%h exp=0", add_y); end
    checks++; if (add_cin !== 1'b0)  begin errors++; $display("FAIL reset_add_cin got=%b exp=0", add_cin); end
    rst_n = 1'b1;
    cyc();
    $display("reset: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
  endtask

  task automatic test_basic();
    int lat;
    start_op(32'd3, 32'd5);
    checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    checks++; if (add_y !== 32'd3)  begin errors++; $display("FAIL basic_step1_add_y got=%h exp=3", add_y); end
    checks++; if (add_x !== 32'd0)  begin errors++; $display("FAIL basic_step1_add_x got=%h exp=0", add_x); end
    wait_done(0, lat);
    checks++; if (lat !== 32)       begin errors++; $display("FAIL basic_latency got=%0d exp=32", lat); end
    checks++; if (hi !== 32'd0)     begin errors++; $display("FAIL basic_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd15)    begin errors++; $display("FAIL basic_lo got=%h exp=f", lo); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
    $display("op 3*5: lat=%0d hi=%h lo=%h", lat, hi, lo);
    cyc();
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    checks++; if (lo !== 32'd15)    begin errors++; $display("FAIL basic_hold_lo got=%h exp=f", lo); end
    checks++; if (add_y !== 32'd0)  begin errors++; $display("FAIL idle_add_y got=%h exp=0", add_y); end

    start_op(32'd0, 32'hDEADBEEF);
    wait_done(0, lat);
    checks++; if (lat !== 32)       begin errors++; $display("FAIL zero_latency got=%0d exp=32", lat); end
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL zero_product got=%h exp=0", {hi, lo}); end
    $display("op 0*deadbeef: lat=%0d hi=%h lo=%h", lat, hi, lo);
    cyc();
  endtask

  task automatic test_full_scale();
    int lat;
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, lat);
    checks++; if (lat !== 32)             begin errors++; $display("FAIL full_latency got=%0d exp=32", lat); end
    checks++; if (hi !== 32'hFFFFFFFE)    begin errors++; $display("FAIL full_hi got=%h exp=fffffffe", hi); end
    checks++; if (lo !== 32'h00000001)    begin errors++; $display("FAIL full_lo got=%h exp=00000001", lo); end
    $display("op ffffffff*ffffffff: lat=%0d hi=%h lo=%h", lat, hi, lo);
    cyc();
  endtask

  task automatic test_busy_ignore();
    int lat;
    start_op(32'd2, 32'd3);
    repeat (9) cyc();
    a     = 32'd7;
    b     = 32'd9;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(10, lat);
    checks++; if (lat !== 32)        begin errors++; $display("FAIL busy_latency got=%0d exp=32", lat); end
    checks++; if (lo !== 32'd6)      begin errors++; $display("FAIL busy_ignore_lo got=%h exp=6", lo); end
    checks++; if (hi !== 32'd0)      begin errors++; $display("FAIL busy_ignore_hi got=%h exp=0", hi); end
    $display("op 2*3 (start ignored mid-run): lat=%0d hi=%h lo=%h", lat, hi, lo);
    cyc();
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL busy_no_queue got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(32'd2, 32'd3);
    wait_done(0, lat);
    checks++; if (lo !== 32'd6)      begin errors++; $display("FAIL b2b_first_lo got=%h exp=6", lo); end
    start_op(32'd7, 32'd9);
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL b2b_done_cleared got=%b exp=0", done); end
    wait_done(0, lat);
    checks++; if (lat !== 32)        begin errors++; $display("FAIL b2b_latency got=%0d exp=32", lat); end
    checks++; if (lo !== 32'd63)     begin errors++; $display("FAIL b2b_lo got=%h exp=3f", lo); end
    $display("op 7*9 (back-to-back): lat=%0d hi=%h lo=%h", lat, hi, lo);
    cyc();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    start_op(32'h00012345, 32'h00000010);
    repeat (15) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    checks++; if (hi !== 32'd0)      begin errors++; $display("FAIL mid_reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0)      begin errors++; $display("FAIL mid_reset_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    checks++; if (add_x !== 32'd0)   begin errors++; $display("FAIL mid_reset_add_x got=%h exp=0", add_x); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      cyc();
    end
    checks++; if (seen !== 0)        begin errors++; $display("FAIL mid_reset_no_done got=%0d exp=0", seen); end
    start_op(32'h00010000, 32'h00010000);
    wait_done(0, lat);
    checks++; if (lat !== 32)        begin errors++; $display("FAIL post_reset_latency got=%0d exp=32", lat); end
    checks++; if (hi !== 32'd1)      begin errors++; $display("FAIL post_reset_hi got=%h exp=1", hi); end
    checks++; if (lo !== 32'd0)      begin errors++; $display("FAIL post_reset_lo got=%h exp=0", lo); end
    $display("op 10000*10000 (after mid reset): lat=%0d hi=%h lo=%h", lat, hi, lo);
    cyc();
  endtask

`ifdef MULT_SIGNED_EN
  task automatic test_signed();
    int lat;
    sgn = 1'b1;
    start_op(32'hFFFFFFFD, 32'd5);
    wait_done(0, lat);
    checks++; if (lat !== 34)           begin errors++; $display("FAIL sgn_neg_latency got=%0d exp=34", lat); end
    checks++; if (hi !== 32'hFFFFFFFF)  begin errors++; $display("FAIL sgn_neg_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFF1)  begin errors++; $display("FAIL sgn_neg_lo got=%h exp=fffffff1", lo); end
    $display("op -3*5 signed: lat=%0d hi=%h lo=%h", lat, hi, lo);
    cyc();
    start_op(32'hFFFFFFFC, 32'hFFFFFFFC);
    wait_done(0, lat);
    checks++; if (lat !== 34)           begin errors++; $display("FAIL sgn_pos_latency got=%0d exp=34", lat); end
    checks++; if (hi !== 32'd0)         begin errors++; $display("FAIL sgn_pos_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd16)        begin errors++; $display("FAIL sgn_pos_lo got=%h exp=10", lo); end
    $display("op -4*-4 signed: lat=%0d hi=%h lo=%h", lat, hi, lo);
    sgn = 1'b0;
    cyc();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
`ifdef MULT_SIGNED_EN
    sgn   = 1'b0;
`endif
    test_reset();
    test_basic();
    test_full_scale();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef MULT_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

- Sequential 32x32 unsigned shift-and-add multiplier controller.
- Owns no adder of its own: it time-shares the processor's external 32-bit ripple adder (FULL_ADDER_32) through a dedicated operand/result port pair, one add per cycle.
- Produces a 64-bit product in HI/LO for MULTU-class instructions.
- Sits beside the ALU and stalls the pipeline via `busy`.

## Interface

Parameters:
- `WIDTH`, 32: operand width; the product is 2*WIDTH. Only 32 is verified.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; sampled only when `busy`=0.
- `a`  in  32  multiplicand; captured on the accepted `start` edge.
- `b`  in  32  multiplier; captured on the accepted `start` edge.
- `add_x`  out  32  adder operand x.
- `add_y`  out  32  adder operand y.
- `add_cin`  out  1  adder carry-in.
- `add_sum`  in  32  adder sum (combinational return).
- `add_cout`  in  1  adder carry-out.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `hi`  out  32  product upper word.
- `lo`  out  32  product lower word.

## Operation

- States:
  - IDLE -> RUN on `start`=1 while in IDLE.
  - RUN -> IDLE after step 32.
  - With the macro defined: RUN -> FIX1 -> FIX2 -> IDLE.
- Load (accepting edge):
  - mcand <= `a`; `hi` <= 0; `lo` <= `b`; count <= 0; `busy` <= 1.
- RUN step, one per cycle:
  - `add_x`=`hi`.
  - `add_y`=`lo[0]` ? mcand : 0.
  - `add_cin`=0.
  - On the edge: {`hi`,`lo`} <= {`add_cout`, `add_sum`, `lo[31:1]`}; count <= count+1.
- Step 32 is the one taken when count==31 (6-bit counter, no wrap).
  - On that edge `busy` <= 0 and `done` <= 1.
- Outside RUN/FIX, `add_x`, `add_y` and `add_cin` are all 0.
- `hi`/`lo` hold their value until the next accepted `start`.
- `start` while `busy`=1 is ignored, with no queuing.
- `start` in the cycle `done`=1 is accepted; this allows back-to-back operations.

## Timing

Reset values: state IDLE; `hi`=0, `lo`=0, `busy`=0, `done`=0, count=0, mcand=0.

- Start accepted at edge k: `busy`=1 from cycle k+1.
- Steps occur on edges k+1 .. k+32.
- `done`=1 and the final `hi`/`lo` are valid in the cycle after edge k+32, so latency is 32 cycles.
- `done` is high for exactly one cycle.
- `busy` is 0 in the cycle where `done`=1.
- `rst_n`=0 at any edge, including mid-RUN, forces all reset values on that edge.
  - The partial product is discarded and no `done` pulse is produced.
- The adder is combinational with a single-cycle path: `add_sum` must settle within the same cycle.

## Configuration

- `MULT_SIGNED_EN`, defined: adds input port `sgn` (1 bit), sampled with `start`.
  - Load captures magnitudes |a| and |b| (internal ~x+1) when `sgn`=1.
  - Records neg = a[31]^b[31].
  - After RUN, FIX1 and FIX2 use the shared adder to conditionally negate the result:
    - FIX1: `add_x`=neg ? ~`lo` : `lo`; `add_y`=0; `add_cin`=neg.
    - FIX2: `add_x`=neg ? ~`hi` : `hi`; `add_y`=0; `add_cin`=carry from FIX1 when neg, else 0.
  - When `sgn`=1, latency is fixed at 34 cycles regardless of neg.
  - When `sgn`=0, FIX states are skipped and latency is 32.
- `MULT_SIGNED_EN` undefined: no `sgn` port, no FIX states, unsigned only.

## Test plan

- Reset then idle: `rst_n`=0 for 2 cycles -> `hi`=0, `lo`=0, `busy`=0, `done`=0, and all adder operand ports 0.
- Basic unsigned: `a`=3, `b`=5, `start` pulse -> `done` exactly 32 cycles later with `hi`=0, `lo`=15. Same check for `a`=0, `b`=0xDEADBEEF -> product 0.
- Full-scale: `a`=`b`=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. Checks the `add_cout` capture.
- Busy and back-to-back:
  - `start` with `a`=7, `b`=9 at cycle 10 of a running 2x3 operation -> ignored; result 6.
  - `start` in the `done` cycle (`a`=7, `b`=9) -> accepted; `lo`=63 after 32 more cycles.
- Reset mid-operation: `rst_n`=0 at step 16 -> reset values next cycle, no `done`. A new `start` afterwards gives the correct product.
- `MULT_SIGNED_EN`, `sgn`=1, 34-cycle latency for every case:
  - `a`=-3, `b`=5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
  - `a`=-4, `b`=-4 -> `hi`=0, `lo`=16.
